// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: shares one chip8_ram port between video scanout, cpu and ppu.
// Video has priority up to VID_BURST back-to-back grants; cpu/ppu alternate round-robin.
module chip8_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int VID_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    input  logic                  ppu_req,
    input  logic                  ppu_we,
    input  logic [ADDR_WIDTH-1:0] ppu_addr,
    input  logic [DATA_WIDTH-1:0] ppu_wdata,
    output logic                  ppu_gnt,
    output logic                  ppu_rvalid,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_gnt,
    output logic                  vid_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);
    logic                  last_winner;  // 1 = ppu won the last cpu/ppu grant
    logic [3:0]            vid_run;
    logic                  any_req, pick_cpu, granted, we_sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    always_comb begin
        any_req           = cpu_req | ppu_req;
        pick_cpu          = cpu_req & (~ppu_req | last_winner);
        vid_gnt           = ~reset & vid_req & ~(any_req & (vid_run == 4'(VID_BURST)));
        cpu_gnt           = ~reset & ~vid_gnt & pick_cpu;
        ppu_gnt           = ~reset & ~vid_gnt & ppu_req & ~pick_cpu;
        granted           = vid_gnt | cpu_gnt | ppu_gnt;
        we_sel            = cpu_gnt ? cpu_we : ppu_gnt ? ppu_we : 1'b0;
        addr_sel          = vid_gnt ? vid_addr : cpu_gnt ? cpu_addr : ppu_gnt ? ppu_addr : '0;
        wdata_sel         = cpu_gnt ? cpu_wdata : ppu_gnt ? ppu_wdata : '0;
        mem_read_enable   = granted & ~we_sel;
        mem_write_enable  = granted & we_sel;
        mem_read_address  = mem_read_enable ? addr_sel : '0;
        mem_write_address = mem_write_enable ? addr_sel : '0;
        mem_write_data    = mem_write_enable ? wdata_sel : '0;
    end

    assign rdata = mem_read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= 1'b1;
            vid_run     <= '0;
            cpu_rvalid  <= 1'b0;
            ppu_rvalid  <= 1'b0;
            vid_rvalid  <= 1'b0;
        end else begin
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            ppu_rvalid  <= ppu_gnt & ~ppu_we;
            vid_rvalid  <= vid_gnt;
            last_winner <= cpu_gnt ? 1'b0 : ppu_gnt ? 1'b1 : last_winner;
            // the run only counts video grants that made cpu/ppu wait
            vid_run     <= (cpu_gnt | ppu_gnt | ~any_req) ? 4'd0 : vid_gnt ? vid_run + 4'd1 : vid_run;
        end
    end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: directed checks of the arbiter against a behavioural chip8_ram.
module tb_chip8_mem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, ppu_req = 0, ppu_we = 0, vid_req = 0;
    logic [11:0] cpu_addr = 0, ppu_addr = 0, vid_addr = 0;
    logic [7:0]  cpu_wdata = 0, ppu_wdata = 0;
    logic        cpu_gnt, cpu_rvalid, ppu_gnt, ppu_rvalid, vid_gnt, vid_rvalid;
    logic [7:0]  rdata, mem_write_data, mem_read_data;
    logic [11:0] mem_read_address, mem_write_address;
    logic        mem_read_enable, mem_write_enable;
    logic [7:0]  ram [0:4095];
    int          n_cmp = 0, n_err = 0;

    chip8_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_gnt(ppu_gnt), .ppu_rvalid(ppu_rvalid),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
        .rdata(rdata), .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
        if (mem_read_enable) mem_read_data <= ram[mem_read_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        mem_read_data = 8'h00;
        cpu_req = 1; ppu_req = 1; vid_req = 1;
        cyc(); cyc();
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_ppu_gnt", ppu_gnt, 0);
        check("rst_vid_gnt", vid_gnt, 0);
        check("rst_rd_en", mem_read_enable, 0);
        check("rst_wr_en", mem_write_enable, 0);
        check("rst_rvalid", {cpu_rvalid, ppu_rvalid, vid_rvalid}, 0);
        check("rst_rd_addr", mem_read_address, 0);
        cpu_req = 0; ppu_req = 0; vid_req = 0;
        reset = 0;
        cyc();
        check("idle_rd_en", mem_read_enable, 0);
        // cpu write then read-back of 0x141
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h141; cpu_wdata = 8'hAB;
        #1;
        check("wr_gnt", cpu_gnt, 1);
        check("wr_en", mem_write_enable, 1);
        check("wr_rd_en", mem_read_enable, 0);
        check("wr_addr", mem_write_address, 12'h141);
        check("wr_data", mem_write_data, 8'hAB);
        cyc();
        cpu_we = 0;
        #1;
        check("rd_gnt", cpu_gnt, 1);
        check("rd_en", mem_read_enable, 1);
        check("rd_addr", mem_read_address, 12'h141);
        check("wr_no_rvalid", cpu_rvalid, 0);
        cyc();
        cpu_req = 0;
        #1;
        check("rd_rvalid", cpu_rvalid, 1);
        check("rd_data", rdata, 8'hAB);
        check("nogrant_wr_addr", mem_write_address, 0);
        check("nogrant_en", {mem_read_enable, mem_write_enable}, 0);
        cyc();
        check("rvalid_one_cycle", cpu_rvalid, 0);
        // round-robin after reset: cpu wins the first tie
        reset = 1;
        cyc();
        reset = 0;
        cpu_req = 1; cpu_addr = 12'h200; ppu_req = 1; ppu_we = 0; ppu_addr = 12'h300;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_cpu_gnt", cpu_gnt, (i % 2) == 0);
            check("rr_ppu_gnt", ppu_gnt, (i % 2) == 1);
            check("rr_addr", mem_read_address, (i % 2) ? 12'h300 : 12'h200);
            if (i > 0) check("rr_ppu_rvalid", ppu_rvalid, (i % 2) == 0);
            cyc();
        end
        cpu_req = 0; ppu_req = 0;
        cyc();
        // video alone: granted every cycle, rvalid from its second cycle
        vid_req = 1; vid_addr = 12'h100;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("vid_gnt", vid_gnt, 1);
            check("vid_rvalid", vid_rvalid, i > 0);
            cyc();
        end
        // video + cpu: four video grants, then one cpu grant, repeating
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h210;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("burst_vid_gnt", vid_gnt, (i % 5) != 4);
            check("burst_cpu_gnt", cpu_gnt, (i % 5) == 4);
            cyc();
        end
        cpu_req = 0; vid_req = 0;
        cyc();
        // reset in the cycle a ppu read is granted
        ppu_req = 1; ppu_we = 0; ppu_addr = 12'h155;
        #1;
        check("prst_gnt_before", ppu_gnt, 1);
        reset = 1;
        #1;
        check("prst_gnt", ppu_gnt, 0);
        check("prst_rd_en", mem_read_enable, 0);
        check("prst_rd_addr", mem_read_address, 0);
        cyc();
        check("prst_rvalid", ppu_rvalid, 0);
        check("prst_gnts", {cpu_gnt, ppu_gnt, vid_gnt}, 0);
        ppu_req = 0;
        reset = 0;
        cyc();
        // ppu write of 0x0F to 0x141 racing a video read of the same byte
        vid_req = 1; vid_addr = 12'h141;
        ppu_req = 1; ppu_we = 1; ppu_addr = 12'h141; ppu_wdata = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("race_vid_gnt", vid_gnt, i < 4);
            check("race_ppu_gnt", ppu_gnt, i == 4);
            if (i > 0) begin
                check("race_old_rvalid", vid_rvalid, 1);
                check("race_old_data", rdata, 8'hAB);
            end
            cyc();
        end
        ppu_req = 0;
        #1;
        check("race_vid_after", vid_gnt, 1);
        check("race_no_rvalid", vid_rvalid, 0);
        cyc();
        check("race_new_rvalid", vid_rvalid, 1);
        check("race_new_data", rdata, 8'h0F);
        vid_req = 0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
